memory_cycle: RTL
=================

MEMORY_CYCLE -- requirements
Module: memory_cycle

Interface
REQ-001 Parameter DEPTH, default 256, data-memory size in 32-bit words (power of two).
REQ-002 Parameter AW, default 8, word-index width, log2(DEPTH).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 RegWriteM  input  1  memory-stage register-write enable.
REQ-006 MemWriteM  input  1  store request.
REQ-007 ResultSrcM  input  1  0 = ALU result, 1 = load data.
REQ-008 RD_M  input  5  destination register index.
REQ-009 PCPlus4M  input  32  PC+4 of the instruction.
REQ-010 WriteDataM  input  32  store data.
REQ-011 ALU_ResultM  input  32  byte address for load/store, or ALU result.
REQ-012 FlushM  input  1  turn the current memory-stage instruction into a bubble.
REQ-013 RegWriteW  output  1  registered write-back enable.
REQ-014 RD_W  output  5  registered destination index.
REQ-015 PCPlus4W  output  32  registered PC+4.
REQ-016 ResultW  output  32  write-back value, combinational from W registers.
REQ-017 MisalignErr  output  1  sticky misaligned-access flag.
REQ-018 LoadCount, StoreCount  output  16 each  committed load/store counters.

Function
REQ-019 Word index is ALU_ResultM[AW+1:2]; higher address bits are ignored, so addresses wrap modulo DEPTH*4.
REQ-020 Access is misaligned when ALU_ResultM[1:0] != 0 and (MemWriteM or ResultSrcM) is 1.
REQ-021 Store commits at the rising edge when MemWriteM=1, FlushM=0 and the access is aligned: mem[index] <= WriteDataM.
REQ-022 A misaligned store is suppressed, and memory is unchanged.
REQ-023 Load data is read combinationally from mem[index] and captured in ReadDataW at the same edge.
REQ-024 Read and write to the same index in the same cycle captures the old (pre-write) word.
REQ-025 A misaligned load captures ReadDataW = 0.
REQ-026 Each cycle the M->W register captures:
- RegWriteW <= RegWriteM & ~FlushM;
- RD_W, PCPlus4W, ALUResultW, ResultSrcW from the M inputs;
- ReadDataW as defined in REQ-023/REQ-025.
REQ-027 When FlushM=1, the captured values are RegWriteW=0, RD_W=0, PCPlus4W=0, ALUResultW=0, ResultSrcW=0, ReadDataW=0.
REQ-028 ResultW = ResultSrcW ? ReadDataW : ALUResultW.
REQ-029 Latency: one cycle from M inputs to W outputs. The stage has no stall; an instruction is accepted every cycle.
REQ-030 MisalignErr sets at the edge of any misaligned access with FlushM=0, and stays at 1 until reset.
REQ-031 StoreCount increments at each committed store (REQ-021).
REQ-032 LoadCount increments at each edge with ResultSrcM=1, FlushM=0 and an aligned address.
REQ-033 Both counters saturate at 16'hFFFF; they do not wrap.
REQ-034 RegWriteM=1 with RD_M=0 is passed through unchanged; the register file handles x0.

Reset
REQ-035 While rst=1, all of the following are 0: RegWriteW, RD_W, PCPlus4W, ALUResultW, ResultSrcW, ReadDataW, MisalignErr, LoadCount, StoreCount.
REQ-036 While rst=1, ResultW=0 and every memory word is cleared to 0.
REQ-037 Reset asserted mid-operation takes effect immediately, without waiting for a clock edge.
REQ-038 A store presented in the same cycle as reset does not commit.
REQ-039 Normal operation resumes at the first rising edge after rst deasserts.

Verification
REQ-040 Store then load: store 32'hDEADBEEF at 0x10, then load 0x10 with RD_M=5 and RegWriteM=1 -> next cycle ResultW=32'hDEADBEEF, RD_W=5, RegWriteW=1, StoreCount=1, LoadCount=1.
REQ-041 Same-cycle read/write: mem[0x20]=1, then store 2 to 0x20 with ResultSrcM=1 in the same cycle -> ResultW=1; a following load of 0x20 gives 2.
REQ-042 Misaligned store to 0x13 -> mem[4] unchanged, MisalignErr=1 and held, StoreCount unchanged.
REQ-043 Flush: store 32'h5 to 0x0 with FlushM=1 and RegWriteM=1 -> mem[0] stays 0, RegWriteW=0, ResultW=0, counters unchanged.
REQ-044 Wrap and pass-through: with DEPTH=256, store 7 to 0x400 -> load 0x0 returns 7; an ALU op with ALU_ResultM=32'h1234 and ResultSrcM=0 gives ResultW=32'h1234 one cycle later.
REQ-045 Reset and saturation: assert rst between edges -> all outputs 0 immediately; 65540 aligned loads -> LoadCount=16'hFFFF.

Source files
------------

// File: rtl/memory_cycle_if.sv
// Memory-stage to write-back bundle: M-stage inputs in, registered W-stage results out.
interface memory_cycle_if;
  logic        RegWriteM;
  logic        MemWriteM;
  logic        ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M;
  logic [31:0] WriteDataM;
  logic [31:0] ALU_ResultM;
  logic        FlushM;

  logic        RegWriteW;
  logic [4:0]  RD_W;
  logic [31:0] PCPlus4W;
  logic [31:0] ResultW;
  logic        MisalignErr;
  logic [15:0] LoadCount;
  logic [15:0] StoreCount;

  modport master (
    output RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM, FlushM,
    input  RegWriteW, RD_W, PCPlus4W, ResultW, MisalignErr, LoadCount, StoreCount
  );

  modport slave (
    input  RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM, FlushM,
    output RegWriteW, RD_W, PCPlus4W, ResultW, MisalignErr, LoadCount, StoreCount
  );
endinterface

// File: rtl/memory_cycle.sv
// Pipeline memory stage: word-addressed data memory, M->W register, misalign flag and
// saturating load/store commit counters.
module memory_cycle #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  memory_cycle_if.slave bus
);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx;
  logic          misaligned;
  logic          store_commit;
  logic          load_commit;
  logic [31:0]   read_data_next;

  logic          result_src_w;
  logic [31:0]   alu_result_w;
  logic [31:0]   read_data_w;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    idx            = bus.ALU_ResultM[AW+1:2];
    misaligned     = 1'b0;
    store_commit   = 1'b0;
    load_commit    = 1'b0;
    read_data_next = '0;
    if ((bus.MemWriteM || bus.ResultSrcM) && (bus.ALU_ResultM[1:0] != 2'b00))
      misaligned = 1'b1;
    if (!bus.FlushM && !misaligned) begin
      store_commit   = bus.MemWriteM;
      load_commit    = bus.ResultSrcM;
      // Sampled before the edge, so a same-index store is seen as the old word.
      read_data_next = mem[idx];
    end
  end

  // NOTE: the memory is cleared by reset because the stage must read back zeros after
  // any reset; this forces a flop array rather than an SRAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (store_commit) begin
      mem[idx] <= bus.WriteDataM;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.RegWriteW <= 1'b0;
      bus.RD_W      <= '0;
      bus.PCPlus4W  <= '0;
      alu_result_w  <= '0;
      result_src_w  <= 1'b0;
      read_data_w   <= '0;
    end else if (bus.FlushM) begin
      bus.RegWriteW <= 1'b0;
      bus.RD_W      <= '0;
      bus.PCPlus4W  <= '0;
      alu_result_w  <= '0;
      result_src_w  <= 1'b0;
      read_data_w   <= '0;
    end else begin
      bus.RegWriteW <= bus.RegWriteM;
      bus.RD_W      <= bus.RD_M;
      bus.PCPlus4W  <= bus.PCPlus4M;
      alu_result_w  <= bus.ALU_ResultM;
      result_src_w  <= bus.ResultSrcM;
      read_data_w   <= read_data_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.MisalignErr <= 1'b0;
      bus.LoadCount   <= '0;
      bus.StoreCount  <= '0;
    end else begin
      if (misaligned && !bus.FlushM) bus.MisalignErr <= 1'b1;
      if (load_commit && (bus.LoadCount != 16'hFFFF))
        bus.LoadCount <= bus.LoadCount + 16'd1;
      if (store_commit && (bus.StoreCount != 16'hFFFF))
        bus.StoreCount <= bus.StoreCount + 16'd1;
    end
  end

  assign bus.ResultW = result_src_w ? read_data_w : alu_result_w;

endmodule
